// File: rtl/output_layer_mac.sv
// output_layer_mac: final dense layer of the digit classifier.
// Each accepted activation feeds ten parallel MACs against one weight ROM row.
// After N_IN beats the bias row is read and added to every accumulator.
// The ten scores are MSB-flipped and packed in reverse neuron order for the argmax stage.
module output_layer_mac #(
    parameter  int N_IN   = 64,
    parameter  int IN_W   = 16,
    parameter  int W_W    = 16,
    parameter  int WIDTH  = 40,
    localparam int ADDR_W = $clog2(N_IN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    output logic [ADDR_W-1:0]   weight_addr,
    input  logic [10*W_W-1:0]   weight_data,
    output logic [10*WIDTH-1:0] scores,
    output logic                scores_valid
);

    typedef enum logic [1:0] {
        ACCUM,
        BIAS_RD,
        BIAS_ADD
    } state_t;

    localparam int                PROD_W   = IN_W + W_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] BIAS_IDX = ADDR_W'(N_IN);
    localparam logic [WIDTH-1:0]  MSB_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_cnt;
    logic [IN_W-1:0]            r_act_d;
    logic                       r_act_vld;
    logic [WIDTH-1:0]           r_acc [10];
    logic [10*WIDTH-1:0]        r_scores;
    logic                       r_scores_valid;

    logic                       w_hs;
    logic signed [PROD_W-1:0]   w_prod     [10];
    logic [WIDTH-1:0]           w_prod_ext [10];
    logic [WIDTH-1:0]           w_bias_ext [10];

    // Ready only while accumulating and never during reset.
    assign in_ready     = (r_state == ACCUM) && !reset;
    assign w_hs         = in_valid && in_ready;
    assign scores       = r_scores;
    assign scores_valid = r_scores_valid;

    // ROM address: current activation index while accumulating, bias row otherwise.
    always_comb begin
        weight_addr = '0;
        if (!reset) begin
            weight_addr = (r_state == ACCUM) ? r_cnt : BIAS_IDX;
        end
    end

    // Signed products and bias terms, sign-extended to accumulator width.
    always_comb begin
        for (int unsigned j = 0; j < 10; j++) begin
            w_prod[j]     = PROD_W'($signed(r_act_d)) *
                            PROD_W'($signed(weight_data[j*W_W +: W_W]));
            w_prod_ext[j] = WIDTH'(w_prod[j]);
            w_bias_ext[j] = WIDTH'($signed(weight_data[j*W_W +: W_W]));
        end
    end

    // Control FSM, activation pipeline register, MAC array and score register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ACCUM;
            r_cnt          <= '0;
            r_act_d        <= '0;
            r_act_vld      <= 1'b0;
            r_scores       <= '0;
            r_scores_valid <= 1'b0;
            for (int unsigned j = 0; j < 10; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_scores_valid <= 1'b0;
            r_act_vld      <= w_hs;
            if (w_hs) begin
                r_act_d <= in_data;
            end
            // The ROM row for a beat arrives one cycle after its handshake.
            if (r_act_vld) begin
                for (int unsigned j = 0; j < 10; j++) begin
                    r_acc[j] <= r_acc[j] + w_prod_ext[j];
                end
            end
            case (r_state)
                ACCUM: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= BIAS_RD;
                        end
                    end
                end
                BIAS_RD: begin
                    r_state <= BIAS_ADD;
                end
                BIAS_ADD: begin
                    for (int unsigned j = 0; j < 10; j++) begin
                        r_scores[(9-j)*WIDTH +: WIDTH] <= (r_acc[j] + w_bias_ext[j]) ^ MSB_FLIP;
                        r_acc[j] <= '0;
                    end
                    r_scores_valid <= 1'b1;
                    r_cnt          <= '0;
                    r_state        <= ACCUM;
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Testbench for output_layer_mac with N_IN=4 and a 1-cycle-latency weight ROM.
module tb_output_layer_mac;

    localparam int N_IN  = 4;
    localparam int IN_W  = 16;
    localparam int W_W   = 16;
    localparam int WIDTH = 40;
    localparam int AW    = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [IN_W-1:0]     in_data = '0;
    logic [AW-1:0]       weight_addr;
    logic [10*W_W-1:0]   weight_data;
    logic [10*WIDTH-1:0] scores;
    logic                scores_valid;

    output_layer_mac #(
        .N_IN (N_IN),
        .IN_W (IN_W),
        .W_W  (W_W),
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .scores      (scores),
        .scores_valid(scores_valid)
    );

    always #5 clk = ~clk;

    // Weight ROM model, one cycle read latency.
    logic [159:0] rom [8];
    always @(posedge clk) weight_data <= rom[weight_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every scores_valid pulse with its cycle number.
    int           pulse_cnt = 0;
    logic [399:0] cap_scores [32];
    int           cap_cyc    [32];
    always @(negedge clk) begin
        if (scores_valid === 1'b1) begin
            if (pulse_cnt < 32) begin
                cap_scores[pulse_cnt] <= scores;
                cap_cyc[pulse_cnt]    <= cyc;
            end
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    logic [399:0]       exp_q [$];
    int                 tests = 0;
    int                 fails = 0;
    logic signed [15:0] acts [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [399:0] model();
        logic [399:0] m;
        logic [39:0]  s;
        m = '0;
        for (int j = 0; j < 10; j++) begin
            s = '0;
            for (int k = 0; k < 4; k++) begin
                s = s + 40'(longint'(acts[k]) * longint'($signed(rom[k][j*16 +: 16])));
            end
            s = s + 40'(longint'($signed(rom[4][j*16 +: 16])));
            m[(9-j)*40 +: 40] = s ^ {1'b1, 39'b0};
        end
        return m;
    endfunction

    function automatic int argmax(input logic [399:0] s);
        int best;
        best = 0;
        for (int i = 1; i < 10; i++) begin
            if (s[(9-i)*40 +: 40] > s[(9-best)*40 +: 40]) best = i;
        end
        return best;
    endfunction

    task automatic set_ramp_rom();
        for (int k = 0; k < 8; k++) rom[k] = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 10; j++) rom[k][j*16 +: 16] = 16'(j);
        end
    endtask

    // Drives the four beats in acts; returns cycle of the last accepted beat.
    task automatic send_frame(input int gap, output int t_last, output bit ok);
        int w;
        ok = 1'b1;
        t_last = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = acts[k];
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) ok = 1'b0;
            if (weight_addr !== AW'(k)) ok = 1'b0;
            t_last = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            if (k < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests++; if (weight_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", weight_addr); end
        tests++; if (scores !== '0) begin fails++; $display("FAIL reset_scores: got %h expected 0", scores); end
        tests++; if (scores_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", scores_valid); end
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (scores_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b expected 0", scores_valid); end
    endtask

    task automatic test_single_frame(input string name, input int gap, input int exp_digit);
        int base, t, w;
        bit ok;
        logic [399:0] e;
        exp_q.push_back(model());
        base = pulse_cnt;
        send_frame(gap, t, ok);
        tests++; if (!ok) begin fails++; $display("FAIL %s_handshake: got stalled/bad address expected 4 clean beats", name); end
        w = 0;
        while (cyc < t + 4 && w < 20) begin @(negedge clk); w++; end
        e = exp_q.pop_front();
        tests++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL %s_pulse_count: got %0d expected %0d", name, pulse_cnt - base, 1); end
        tests++; if (cap_cyc[base] !== t + 3) begin fails++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, cap_cyc[base], t + 3); end
        tests++; if (cap_scores[base] !== e) begin fails++; $display("FAIL %s_scores: got %h expected %h", name, cap_scores[base], e); end
        tests++; if (scores_valid !== 1'b0 || scores !== e) begin fails++; $display("FAIL %s_hold: got valid=%b scores=%h expected valid=0 scores=%h", name, scores_valid, scores, e); end
        if (exp_digit >= 0) begin
            tests++; if (argmax(cap_scores[base]) !== exp_digit) begin fails++; $display("FAIL %s_argmax: got %0d expected %0d", name, argmax(cap_scores[base]), exp_digit); end
        end
    endtask

    task automatic test_ramp_pos();
        set_ramp_rom();
        acts = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        test_single_frame("ramp_pos", 0, 9);
        tests++; if (scores[39:0] !== 40'h80_0000_0024) begin fails++; $display("FAIL ramp_pos_field9: got %h expected 8000000024", scores[39:0]); end
        tests++; if (scores[399:360] !== 40'h80_0000_0000) begin fails++; $display("FAIL ramp_pos_field0: got %h expected 8000000000", scores[399:360]); end
    endtask

    task automatic test_ramp_neg();
        set_ramp_rom();
        acts = '{-16'sd1, -16'sd1, -16'sd1, -16'sd1};
        test_single_frame("ramp_neg", 0, 0);
        tests++; if (scores[39:0] !== 40'h7F_FFFF_FFDC) begin fails++; $display("FAIL ramp_neg_field9: got %h expected 7fffffffdc", scores[39:0]); end
    endtask

    task automatic test_bias();
        set_ramp_rom();
        for (int j = 0; j < 10; j++) rom[4][j*16 +: 16] = (j == 3) ? 16'd5 : 16'hFFFE;
        acts = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        test_single_frame("bias", 0, 3);
        tests++; if (scores[279:240] !== 40'h80_0000_0005) begin fails++; $display("FAIL bias_field3: got %h expected 8000000005", scores[279:240]); end
        tests++; if (scores[39:0] !== 40'h7F_FFFF_FFFE) begin fails++; $display("FAIL bias_field9: got %h expected 7ffffffffe", scores[39:0]); end
    endtask

    task automatic test_gaps();
        set_ramp_rom();
        acts = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        test_single_frame("gaps", 2, 9);
    endtask

    task automatic test_reset_midframe();
        int base, w;
        set_ramp_rom();
        base = pulse_cnt;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'd7;
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
        reset = 1'b0;
        @(negedge clk);
        acts = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        test_single_frame("midreset", 0, 9);
        tests++; if (pulse_cnt !== base + 1) begin fails++; $display("FAIL midreset_total_pulses: got %0d expected 1", pulse_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int base, t1, t2, w;
        bit ok1, ok2;
        logic [399:0] e1, e2;
        set_ramp_rom();
        base = pulse_cnt;
        acts = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        exp_q.push_back(model());
        send_frame(0, t1, ok1);
        acts = '{-16'sd1, -16'sd1, -16'sd1, -16'sd1};
        exp_q.push_back(model());
        send_frame(0, t2, ok2);
        tests++; if (!(ok1 && ok2)) begin fails++; $display("FAIL b2b_handshake: got ok1=%b ok2=%b expected 1 1", ok1, ok2); end
        tests++; if (t2 !== t1 + 6) begin fails++; $display("FAIL b2b_restart: got last beat %0d expected %0d", t2, t1 + 6); end
        w = 0;
        while (cyc < t2 + 4 && w < 40) begin @(negedge clk); w++; end
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        tests++; if (pulse_cnt !== base + 2) begin fails++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulse_cnt - base); end
        tests++; if (cap_cyc[base] !== t1 + 3) begin fails++; $display("FAIL b2b_latency1: got %0d expected %0d", cap_cyc[base], t1 + 3); end
        tests++; if (cap_cyc[base+1] !== t2 + 3) begin fails++; $display("FAIL b2b_latency2: got %0d expected %0d", cap_cyc[base+1], t2 + 3); end
        tests++; if (cap_scores[base] !== e1) begin fails++; $display("FAIL b2b_scores1: got %h expected %h", cap_scores[base], e1); end
        tests++; if (cap_scores[base+1] !== e2) begin fails++; $display("FAIL b2b_scores2: got %h expected %h", cap_scores[base+1], e2); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < 10; j++) rom[k][j*16 +: 16] = 16'($urandom);
            end
            for (int k = 0; k < 4; k++) acts[k] = 16'($urandom);
            test_single_frame("random", int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        set_ramp_rom();
        test_reset();
        test_ramp_pos();
        test_ramp_neg();
        test_bias();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
